// File: rtl/udp_stack_regs_pkg.sv
// UDP stack control/status register map.
// Offsets, response codes and decode helpers.
package udp_stack_regs_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_SRC_IP   = 5'h04;
  localparam logic [4:0] OFF_DST_IP   = 5'h08;
  localparam logic [4:0] OFF_PORTS    = 5'h0C;
  localparam logic [4:0] OFF_TX_CNT   = 5'h10;
  localparam logic [4:0] OFF_DROP_CNT = 5'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDX_CTRL     = OFF_CTRL[4:2],
    IDX_SRC_IP   = OFF_SRC_IP[4:2],
    IDX_DST_IP   = OFF_DST_IP[4:2],
    IDX_PORTS    = OFF_PORTS[4:2],
    IDX_TX_CNT   = OFF_TX_CNT[4:2],
    IDX_DROP_CNT = OFF_DROP_CNT[4:2],
    IDX_RSV6     = 3'd6,
    IDX_RSV7     = 3'd7
  } reg_idx_e;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/udp_stack_evt_counter.sv
// Saturating event counter with synchronous clear.
// Clear and pulse together leave the count at one.
module udp_stack_evt_counter
  import udp_stack_regs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= pulse ? WIDTH'(1) : '0;
    end else if (pulse && count != '1) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/udp_stack_axil_regs.sv
// AXI4-Lite slave for UDP stack config and counters.
// AW and W latch independently; read path is separate.
module udp_stack_axil_regs
  import udp_stack_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     ctrl,
  output logic [31:0]                     src_ip,
  output logic [31:0]                     dst_ip,
  output logic [31:0]                     ports,
  input  logic                            tx_pkt_pulse,
  input  logic                            rx_drop_pulse
);

  logic        aw_full, w_full;
  logic        awready_q, wready_q, bvalid_q;
  logic [2:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] ctrl_q, src_ip_q, dst_ip_q, ports_q;
  logic [31:0] tx_cnt, drop_cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic commit, aw_full_nx, w_full_nx, rvalid_nx;
  logic we_ctrl, we_src, we_dst, we_ports;
  logic tx_clr, drop_clr, wr_err;
  logic [31:0] rd_data;
  logic        rd_err;
  reg_idx_e    wr_idx, rd_idx;

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs  = awready_q & S_AXI_AWVALID;
  assign w_hs   = wready_q & S_AXI_WVALID;
  assign b_hs   = bvalid_q & S_AXI_BREADY;
  assign ar_hs  = arready_q & S_AXI_ARVALID;
  assign r_hs   = rvalid_q & S_AXI_RREADY;
  assign commit = aw_full & w_full & ~bvalid_q;

  // Payload stays latched until the response is taken.
  assign aw_full_nx = (aw_full | aw_hs) & ~b_hs;
  assign w_full_nx  = (w_full | w_hs) & ~b_hs;
  assign rvalid_nx  = (rvalid_q & ~S_AXI_RREADY) | ar_hs;

  assign wr_idx = reg_idx_e'(aw_idx_q);
  assign rd_idx = reg_idx_e'(S_AXI_ARADDR[4:2]);

  always_comb begin
    we_ctrl  = 1'b0;
    we_src   = 1'b0;
    we_dst   = 1'b0;
    we_ports = 1'b0;
    tx_clr   = 1'b0;
    drop_clr = 1'b0;
    wr_err   = 1'b0;
    if (commit) begin
      unique case (wr_idx)
        IDX_CTRL:     we_ctrl  = 1'b1;
        IDX_SRC_IP:   we_src   = 1'b1;
        IDX_DST_IP:   we_dst   = 1'b1;
        IDX_PORTS:    we_ports = 1'b1;
        IDX_TX_CNT:   tx_clr   = |wstrb_q;
        IDX_DROP_CNT: drop_clr = |wstrb_q;
        default:      wr_err   = 1'b1;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (rd_idx)
      IDX_CTRL:     rd_data = ctrl_q;
      IDX_SRC_IP:   rd_data = src_ip_q;
      IDX_DST_IP:   rd_data = dst_ip_q;
      IDX_PORTS:    rd_data = ports_q;
      IDX_TX_CNT:   rd_data = tx_cnt;
      IDX_DROP_CNT: rd_data = drop_cnt;
      default:      rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_full   <= aw_full_nx;
      w_full    <= w_full_nx;
      awready_q <= ~aw_full_nx;
      wready_q  <= ~w_full_nx;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[4:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q   <= '0;
      src_ip_q <= '0;
      dst_ip_q <= '0;
      ports_q  <= '0;
    end else begin
      if (we_ctrl)
        ctrl_q <= strb_merge(ctrl_q, wdata_q, wstrb_q);
      if (we_src)
        src_ip_q <= strb_merge(src_ip_q, wdata_q, wstrb_q);
      if (we_dst)
        dst_ip_q <= strb_merge(dst_ip_q, wdata_q, wstrb_q);
      if (we_ports)
        ports_q <= strb_merge(ports_q, wdata_q, wstrb_q);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= ~rvalid_nx;
      rvalid_q  <= rvalid_nx;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  udp_stack_evt_counter #(.WIDTH(32)) u_tx_cnt (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .pulse (tx_pkt_pulse),
    .clr   (tx_clr),
    .count (tx_cnt)
  );

  udp_stack_evt_counter #(.WIDTH(32)) u_drop_cnt (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .pulse (rx_drop_pulse),
    .clr   (drop_clr),
    .count (drop_cnt)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl   = ctrl_q;
  assign src_ip = src_ip_q;
  assign dst_ip = dst_ip_q;
  assign ports  = ports_q;

endmodule

// File: doc/udp_stack_axil_regs.md
UDP_STACK_AXIL_REGS -- requirements
Module: udp_stack_axil_regs

Interface
REQ-001 Parameters SHALL be C_S_AXI_DATA_WIDTH, default 32, bus data width (only 32 supported); C_S_AXI_ADDR_WIDTH, default 5, byte address width.
REQ-002 ACLK  in  1  single clock; all logic rising-edge.
REQ-003 ARESETN  in  1  reset, asynchronous, active-low.
REQ-004 S_AXI_AWADDR in 5, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1: write address channel.
REQ-005 S_AXI_WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write data channel.
REQ-006 S_AXI_BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
REQ-007 S_AXI_ARADDR in 5, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1: read address channel.
REQ-008 S_AXI_RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.
REQ-009 ctrl out 32, src_ip out 32, dst_ip out 32, ports out 32: current contents of the RW registers.
REQ-010 tx_pkt_pulse in 1, rx_drop_pulse in 1: one-cycle event strobes from the datapath.

Function
REQ-011 Register map (word offset): 0x00 CTRL RW, 0x04 SRC_IP RW, 0x08 DST_IP RW, 0x0C PORTS RW, 0x10 TX_CNT RO/clear, 0x14 DROP_CNT RO/clear; 0x18-0x1C unmapped.
REQ-012 Address bits [1:0] SHALL be ignored; decode uses bits [4:2].
REQ-013 AW and W SHALL be accepted independently; each handshake latches its payload and drops its READY until the write completes.
REQ-014 Write commits in the cycle both AW and W are latched and BVALID is low; BVALID asserts the next cycle.
REQ-015 BVALID SHALL hold until BREADY; AWREADY and WREADY reassert the cycle after the B handshake.
REQ-016 RW writes SHALL apply WSTRB per byte; WSTRB = 0 leaves the register unchanged, BRESP OKAY.
REQ-017 A write to 0x10 or 0x14 with any WSTRB bit set SHALL clear that counter; BRESP OKAY.
REQ-018 A write to an unmapped offset SHALL change no state and return BRESP SLVERR (2'b10).
REQ-019 ARREADY SHALL be high when RVALID is low; after the AR handshake RVALID asserts the next cycle with RDATA captured.
REQ-020 RDATA/RRESP SHALL hold stable until RREADY; ARREADY reasserts the cycle after the R handshake.
REQ-021 An unmapped read SHALL return RDATA 0, RRESP SLVERR; mapped reads return OKAY.
REQ-022 Read and write paths SHALL be independent and may complete in the same cycle.
REQ-023 A same-cycle read of a register being written SHALL return the pre-write value.
REQ-024 TX_CNT/DROP_CNT SHALL increment by 1 per pulse and saturate at 0xFFFFFFFF.
REQ-025 A simultaneous clear and pulse SHALL leave the counter at 1.
REQ-026 Write latency (both channels presented together, BREADY high) SHALL be 2 cycles to BVALID; read latency 1 cycle AR handshake to RVALID.

Reset
REQ-027 While ARESETN is low: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, all registers and counters 0.
REQ-028 AWREADY, WREADY and ARREADY SHALL rise on the first ACLK edge after ARESETN deasserts.
REQ-029 Reset mid-transaction SHALL abort it, with no pending response after release.

Structure
REQ-030 Package udp_stack_regs_pkg SHALL hold register offset constants, the RESP_OKAY/RESP_SLVERR codes, and the register index enum.
REQ-031 Sub-module udp_stack_evt_counter (32-bit saturating counter, pulse + clear inputs, REQ-024/025 semantics) SHALL be instantiated twice.

Verification
REQ-032 Write 0x1,0x2,0x3,0x4 to 0x00..0x0C, read back -> RDATA 0x1..0x4, all RESP OKAY; ctrl=1, ports=4.
REQ-033 AW presented 3 cycles before W; then WDATA 0xAABBCCDD, WSTRB 4'b0101 to 0x04 (prior 0) -> src_ip 0x00BB00DD, one BVALID.
REQ-034 Read 0x18; write 0x1C -> RDATA 0 RRESP 2'b10; BRESP 2'b10; no register changes.
REQ-035 5 tx_pkt_pulse then read 0x10 -> 5; write 0x10 in the same cycle as a pulse -> subsequent read 1; preload 0xFFFFFFFE + 3 pulses -> 0xFFFFFFFF.
REQ-036 BREADY/RREADY held low 10 cycles -> BVALID/RVALID and payload stable, READYs low; ARESETN pulsed mid-hold -> all outputs 0, ctrl 0.
